// File: rtl/mmio_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : mmio_ctrl
//  Brief    : Memory-mapped KEY/SW/LED/HEX/timer controller on a 16-byte window
//  Revision : 1.0 - initial release
// ============================================================================
module mmio_ctrl #(
    parameter int                DBITS     = 16,
    parameter int                ABITS     = 16,
    parameter logic [ABITS-1:0]  BASE      = 16'hFFF0,
    parameter int                NKEYS     = 4,
    parameter int                NSW       = 10,
    parameter int                NLEDR     = 10,
    parameter int                NLEDG     = 8,
    parameter int                NHEX      = 4,
    parameter int                TIMER_DIV = 50000
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [ABITS-1:0]    addr,
    input  logic [DBITS-1:0]    wdata,
    input  logic                we,
    output logic                hit,
    output logic [DBITS-1:0]    rdata,
    input  logic [NKEYS-1:0]    key,
    input  logic [NSW-1:0]      sw,
    output logic [NLEDR-1:0]    ledr,
    output logic [NLEDG-1:0]    ledg,
    output logic [7*NHEX-1:0]   hex
);

    localparam int                PW        = (TIMER_DIV > 1) ? $clog2(TIMER_DIV) : 1;
    localparam logic [PW-1:0]     PRESC_MAX = PW'(TIMER_DIV - 1);
    localparam logic [DBITS+15:0] DEAD_EXT  = {{DBITS{1'b0}}, 16'hDEAD};

    localparam logic [2:0] OFF_KEY   = 3'd0;
    localparam logic [2:0] OFF_SW    = 3'd1;
    localparam logic [2:0] OFF_KEDGE = 3'd2;
    localparam logic [2:0] OFF_TIMER = 3'd3;
    localparam logic [2:0] OFF_HEX   = 3'd4;
    localparam logic [2:0] OFF_LEDR  = 3'd5;
    localparam logic [2:0] OFF_LEDG  = 3'd6;
    localparam logic [2:0] OFF_TCTL  = 3'd7;

    logic [2:0]        off;
    logic              wr;
    logic              wr_kedge, wr_timer, wr_hex, wr_ledr, wr_ledg, wr_tctl;
    logic              unused_addr_lsb;

    logic [NKEYS-1:0]  key_s1, key_s2, key_d;
    logic [NSW-1:0]    sw_s1, sw_s2;
    logic [NKEYS-1:0]  kedge, kedge_set, kedge_clr;

    logic [PW-1:0]     presc;
    logic [DBITS-1:0]  timer;
    logic              en, ovf;
    logic              tick, tick_wrap;

    logic [4*NHEX-1:0] hex_reg;
    logic [NLEDR-1:0]  ledr_reg;
    logic [NLEDG-1:0]  ledg_reg;

    // Byte lane select is irrelevant: every register is a full bus word.
    assign unused_addr_lsb = addr[0];

    assign off      = addr[3:1];
    assign hit      = (addr[ABITS-1:4] == BASE[ABITS-1:4]);
    assign wr       = we && hit;
    assign wr_kedge = wr && (off == OFF_KEDGE);
    assign wr_timer = wr && (off == OFF_TIMER);
    assign wr_hex   = wr && (off == OFF_HEX);
    assign wr_ledr  = wr && (off == OFF_LEDR);
    assign wr_ledg  = wr && (off == OFF_LEDG);
    assign wr_tctl  = wr && (off == OFF_TCTL);

    // Sync flops reset to the unpressed level so release never fakes a press.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            key_s1 <= '1;
            key_s2 <= '1;
            key_d  <= '1;
            sw_s1  <= '0;
            sw_s2  <= '0;
        end else begin
            key_s1 <= key;
            key_s2 <= key_s1;
            key_d  <= key_s2;
            sw_s1  <= sw;
            sw_s2  <= sw_s1;
        end
    end

    assign kedge_set = key_d & ~key_s2;
    assign kedge_clr = wr_kedge ? wdata[NKEYS-1:0] : '0;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            kedge <= '0;
        end else begin
            kedge <= (kedge & ~kedge_clr) | kedge_set;
        end
    end

    assign tick      = en && !wr_timer && (presc == PRESC_MAX);
    assign tick_wrap = tick && (&timer);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            presc <= '0;
            timer <= '0;
        end else if (wr_timer) begin
            presc <= '0;
            timer <= wdata;
        end else if (en) begin
            if (presc == PRESC_MAX) begin
                presc <= '0;
                timer <= timer + 1'b1;
            end else begin
                presc <= presc + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            en  <= 1'b0;
            ovf <= 1'b0;
        end else begin
            if (wr_tctl) begin
                en <= wdata[0];
            end
            if (tick_wrap) begin
                ovf <= 1'b1;
            end else if (wr_tctl && wdata[1]) begin
                ovf <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hex_reg  <= '0;
            ledr_reg <= '0;
            ledg_reg <= '0;
        end else begin
            if (wr_hex) begin
                hex_reg <= wdata[4*NHEX-1:0];
            end
            if (wr_ledr) begin
                ledr_reg <= wdata[NLEDR-1:0];
            end
            if (wr_ledg) begin
                ledg_reg <= wdata[NLEDG-1:0];
            end
        end
    end

    assign ledr = ledr_reg;
    assign ledg = ledg_reg;

    always_comb begin
        rdata = '0;
        if (!hit) begin
            rdata = DEAD_EXT[DBITS-1:0];
        end else begin
            case (off)
                OFF_KEY:   rdata[NKEYS-1:0]  = key_s2;
                OFF_SW:    rdata[NSW-1:0]    = sw_s2;
                OFF_KEDGE: rdata[NKEYS-1:0]  = kedge;
                OFF_TIMER: rdata             = timer;
                OFF_HEX:   rdata[4*NHEX-1:0] = hex_reg;
                OFF_LEDR:  rdata[NLEDR-1:0]  = ledr_reg;
                OFF_LEDG:  rdata[NLEDG-1:0]  = ledg_reg;
                OFF_TCTL:  rdata[1:0]        = {ovf, en};
                default:   rdata             = '0;
            endcase
        end
    end

    // Active-low segments, bit order {g,f,e,d,c,b,a}.
    function automatic logic [6:0] seg7(input logic [3:0] n);
        case (n)
            4'h0:    seg7 = 7'b1000000;
            4'h1:    seg7 = 7'b1111001;
            4'h2:    seg7 = 7'b0100100;
            4'h3:    seg7 = 7'b0110000;
            4'h4:    seg7 = 7'b0011001;
            4'h5:    seg7 = 7'b0010010;
            4'h6:    seg7 = 7'b0000010;
            4'h7:    seg7 = 7'b1111000;
            4'h8:    seg7 = 7'b0000000;
            4'h9:    seg7 = 7'b0010000;
            4'hA:    seg7 = 7'b0001000;
            4'hB:    seg7 = 7'b0000011;
            4'hC:    seg7 = 7'b1000110;
            4'hD:    seg7 = 7'b0100001;
            4'hE:    seg7 = 7'b0000110;
            default: seg7 = 7'b0001110;
        endcase
    endfunction

    for (genvar i = 0; i < NHEX; i++) begin : g_hex
        assign hex[7*i +: 7] = seg7(hex_reg[4*i +: 4]);
    end

endmodule
`default_nettype wire

// File: tb/tb_mmio_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mmio_ctrl
//  Brief    : Directed self-checking bench for mmio_ctrl (TIMER_DIV = 3)
//  Revision : 1.0 - initial release
// ============================================================================
module tb_mmio_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] addr;
    logic [15:0] wdata;
    logic        we;
    logic        hit;
    logic [15:0] rdata;
    logic [3:0]  key;
    logic [9:0]  sw;
    logic [9:0]  ledr;
    logic [7:0]  ledg;
    logic [27:0] hex;

    int checks = 0;
    int errors = 0;

    localparam logic [6:0] S0 = 7'b1000000;
    localparam logic [6:0] S1 = 7'b1111001;
    localparam logic [6:0] S3 = 7'b0110000;
    localparam logic [6:0] SA = 7'b0001000;
    localparam logic [6:0] SF = 7'b0001110;

    mmio_ctrl #(.TIMER_DIV(3)) dut (
        .clk   (clk),
        .reset (reset),
        .addr  (addr),
        .wdata (wdata),
        .we    (we),
        .hit   (hit),
        .rdata (rdata),
        .key   (key),
        .sw    (sw),
        .ledr  (ledr),
        .ledg  (ledg),
        .hex   (hex)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic wr(input logic [15:0] a, input logic [15:0] d);
        @(negedge clk);
        addr  = a;
        wdata = d;
        we    = 1'b1;
        @(negedge clk);
        we    = 1'b0;
    endtask

    task automatic rd(input logic [15:0] a, input string tag, input logic [15:0] exp);
        addr = a;
        #1;
        check(tag, {16'h0, rdata}, {16'h0, exp});
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        reset = 1'b1;
        addr  = 16'h0;
        wdata = 16'h0;
        we    = 1'b0;
        key   = 4'hF;
        sw    = 10'h0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        rd(16'hFFF6, "rst_timer", 16'h0);
        rd(16'hFFF8, "rst_hexreg", 16'h0);
        rd(16'hFFFA, "rst_ledr", 16'h0);
        @(negedge clk);
        rd(16'hFFFC, "rst_ledg", 16'h0);
        rd(16'hFFFE, "rst_tctl", 16'h0);
        rd(16'hFFF0, "rst_key", 16'h000F);
        @(negedge clk);
        rd(16'hFFF4, "rst_kedge", 16'h0);
        check("rst_hex", {4'h0, hex}, {4'h0, {4{S0}}});
        check("rst_ledr_out", {22'h0, ledr}, 32'h0);
        @(negedge clk);
        rd(16'h0100, "miss_rdata", 16'hDEAD);
        check("miss_hit", {31'h0, hit}, 32'h0);
        rd(16'hFFF0, "win_key", 16'h000F);
        check("win_hit", {31'h0, hit}, 32'h1);

        wr(16'hFFFA, 16'h03FF);
        wr(16'hFFFC, 16'h00A5);
        wr(16'hFFF8, 16'h1F3A);
        check("ledr_out", {22'h0, ledr}, 32'h3FF);
        check("ledg_out", {24'h0, ledg}, 32'hA5);
        check("hex_out", {4'h0, hex}, {4'h0, S1, SF, S3, SA});
        rd(16'hFFF8, "hex_readback", 16'h1F3A);
        rd(16'hFFFB, "ledr_odd_addr", 16'h03FF);

        wr(16'hFFFC, 16'hFFFF);
        rd(16'hFFFC, "ledg_upper_zero", 16'h00FF);
        wr(16'h01FC, 16'h0012);
        check("miss_write_ignored", {24'h0, ledg}, 32'hFF);
        wr(16'hFFFA, 16'hFC01);
        rd(16'hFFFA, "ledr_upper_ignored", 16'h0001);

        @(negedge clk);
        sw = 10'h2A5;
        @(negedge clk);
        rd(16'hFFF2, "sw_one_edge", 16'h0);
        @(negedge clk);
        rd(16'hFFF2, "sw_two_edges", 16'h02A5);

        @(negedge clk);
        key = 4'hB;
        @(negedge clk);
        rd(16'hFFF0, "key_one_edge", 16'h000F);
        @(negedge clk);
        rd(16'hFFF0, "key_two_edges", 16'h000B);
        rd(16'hFFF4, "kedge_not_yet", 16'h0);
        @(negedge clk);
        rd(16'hFFF4, "kedge_set", 16'h0004);
        key = 4'hF;
        repeat (4) @(negedge clk);
        rd(16'hFFF4, "kedge_sticky", 16'h0004);
        key = 4'hB;
        @(negedge clk);
        wr(16'hFFF4, 16'h0004);
        rd(16'hFFF4, "kedge_set_beats_clr", 16'h0004);
        wr(16'hFFF4, 16'h0004);
        rd(16'hFFF4, "kedge_w1c", 16'h0);
        key = 4'hF;
        repeat (4) @(negedge clk);

        wr(16'hFFFE, 16'h0001);
        repeat (2) @(negedge clk);
        rd(16'hFFF6, "timer_pre_tick", 16'h0);
        @(negedge clk);
        rd(16'hFFF6, "timer_tick1", 16'h0001);
        repeat (3) @(negedge clk);
        rd(16'hFFF6, "timer_tick2", 16'h0002);
        wr(16'hFFFE, 16'h0000);
        repeat (5) @(negedge clk);
        rd(16'hFFF6, "timer_hold", 16'h0002);
        rd(16'hFFFE, "tctl_off", 16'h0);

        wr(16'hFFF6, 16'hFFFF);
        wr(16'hFFFE, 16'h0001);
        repeat (2) @(negedge clk);
        rd(16'hFFF6, "timer_pre_wrap", 16'hFFFF);
        @(negedge clk);
        rd(16'hFFF6, "timer_wrap", 16'h0);
        rd(16'hFFFE, "tctl_ovf", 16'h0003);
        wr(16'hFFFE, 16'h0003);
        rd(16'hFFFE, "tctl_ovf_clr", 16'h0001);

        key = 4'hE;
        repeat (3) @(negedge clk);
        key = 4'hF;
        rd(16'hFFF4, "kedge_bit0", 16'h0001);
        wr(16'hFFFA, 16'h0001);
        wr(16'hFFF6, 16'h0005);
        rd(16'hFFF6, "timer_load5", 16'h0005);
        @(negedge clk);
        #1;
        reset = 1'b1;
        rd(16'hFFF6, "async_rst_timer", 16'h0);
        rd(16'hFFF4, "async_rst_kedge", 16'h0);
        rd(16'hFFFA, "async_rst_ledr", 16'h0);
        check("async_rst_ledr_out", {22'h0, ledr}, 32'h0);
        check("async_rst_hex", {4'h0, hex}, {4'h0, {4{S0}}});
        rd(16'hFFFE, "async_rst_tctl", 16'h0);
        rd(16'hFFF0, "async_rst_key", 16'h000F);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        repeat (5) @(negedge clk);
        rd(16'hFFF4, "post_rst_kedge", 16'h0);
        rd(16'hFFF6, "post_rst_timer", 16'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
